// File: rtl/readout_rx_pkg.sv
// Shared types and constants for the readout receive path (state decision unit and friends).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package readout_rx_pkg;

    // Width of a classified qubit state / bin label. Labels at or above the
    // configured number of states mark a bin as "don't care".
    localparam int STATE_WIDTH = 2;

    // Decision-unit sequencer states.
    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_COUNT = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } rx_fsm_t;

    // The unit is busy whenever it owns the bin memory walker or is producing a result.
    function automatic logic fsm_is_busy(input rx_fsm_t s);
        return (s == ST_CLEAR) || (s == ST_SCAN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/random_access_mem.sv
// Simple register-file memory: asynchronous read port, one synchronous write port, no reset.
// Latency: read is combinational, write lands on the next clock edge.
// Backpressure: none, every write strobe is accepted.
module random_access_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents are deliberately not reset; owners clear them by write-back.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/readout_rx_state_decision_unit_multistate.sv
// 2-D I/Q histogram per measurement window, then bins are summed per state label and the argmax is reported.
// Latency: finish_count at cycle t -> valid_meas_result_out at cycle t+NUM_BINS+2.
// Backpressure: none; samples outside a window are dropped, label writes during SCAN are dropped.
module readout_rx_state_decision_unit_multistate
    import readout_rx_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int BIN_HALF_ADDR_WIDTH = 4,
    parameter int NUM_STATES          = 3,
    parameter int BIN_COUNTER_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                label_wr_en,
    input  logic [2*BIN_HALF_ADDR_WIDTH-1:0]    label_wr_addr,
    input  logic [STATE_WIDTH-1:0]              label_wr_data,
    input  logic                                start_count,
    input  logic                                finish_count,
    input  logic                                valid_in,
    input  logic [DATA_WIDTH-1:0]               i_in,
    input  logic [DATA_WIDTH-1:0]               q_in,
    output logic                                busy_out,
    output logic                                valid_meas_result_out,
    output logic [STATE_WIDTH-1:0]              meas_result_out,
    output logic                                overflow_out
);

    localparam int BIN_ADDR_WIDTH = 2 * BIN_HALF_ADDR_WIDTH;
    localparam int NUM_BINS       = 2 ** BIN_ADDR_WIDTH;
    localparam int ACC_WIDTH      = BIN_COUNTER_WIDTH + BIN_ADDR_WIDTH;
    localparam logic [BIN_ADDR_WIDTH-1:0] LAST_ADDR = BIN_ADDR_WIDTH'(NUM_BINS - 1);

    rx_fsm_t state;
    rx_fsm_t state_nxt;

    // Address walker shared by CLEAR and SCAN; it always rests at 0 outside them.
    logic [BIN_ADDR_WIDTH-1:0] walk_addr;

    // Control strobes decoded from the sequencer.
    logic walk_en;
    logic scan_en;
    logic count_en;
    logic open_window;
    logic done_en;

    // Sample binning: flip the sign bit to get offset binary, keep the top bits of each axis.
    logic [DATA_WIDTH-1:0]     i_u;
    logic [DATA_WIDTH-1:0]     q_u;
    logic [BIN_ADDR_WIDTH-1:0] sample_bin;
    logic                      unused_low_bits;

    assign i_u        = {~i_in[DATA_WIDTH-1], i_in[DATA_WIDTH-2:0]};
    assign q_u        = {~q_in[DATA_WIDTH-1], q_in[DATA_WIDTH-2:0]};
    assign sample_bin = {q_u[DATA_WIDTH-1 -: BIN_HALF_ADDR_WIDTH],
                         i_u[DATA_WIDTH-1 -: BIN_HALF_ADDR_WIDTH]};
    assign unused_low_bits = ^{i_u[DATA_WIDTH-BIN_HALF_ADDR_WIDTH-1:0],
                               q_u[DATA_WIDTH-BIN_HALF_ADDR_WIDTH-1:0]};

    // Bin count memory port signals.
    logic [BIN_ADDR_WIDTH-1:0]    cnt_addr;
    logic                         cnt_wr_en;
    logic [BIN_COUNTER_WIDTH-1:0] cnt_wr_data;
    logic [BIN_COUNTER_WIDTH-1:0] cnt_rd;
    logic                         cnt_at_max;
    logic [BIN_COUNTER_WIDTH-1:0] cnt_inc;

    // Label table port signals.
    logic                   lbl_wr_en;
    logic [STATE_WIDTH-1:0] lbl_rd;

    // Per-state accumulators and their argmax.
    logic [ACC_WIDTH-1:0]   acc [NUM_STATES];
    logic [ACC_WIDTH-1:0]   best_val;
    logic [STATE_WIDTH-1:0] best_idx;

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt   = state;
        walk_en     = 1'b0;
        scan_en     = 1'b0;
        count_en    = 1'b0;
        open_window = 1'b0;
        done_en     = 1'b0;
        case (state)
            ST_CLEAR: begin
                walk_en = 1'b1;
                if (walk_addr == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // start_count has priority; a lone finish_count is meaningless here.
                if (start_count) begin
                    open_window = 1'b1;
                    state_nxt   = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // The sample arriving alongside finish_count still belongs to the window.
                count_en = valid_in;
                if (finish_count) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                walk_en = 1'b1;
                scan_en = 1'b1;
                if (walk_addr == LAST_ADDR) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_en   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Walker advances one bin per cycle in CLEAR/SCAN and wraps back to 0 after the last bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_addr <= '0;
        end else if (walk_en) begin
            walk_addr <= walk_addr + 1'b1;
        end
    end

    // Counting uses the sample's bin; CLEAR and SCAN both write zero behind the walker.
    assign cnt_at_max  = &cnt_rd;
    assign cnt_inc     = cnt_at_max ? cnt_rd : cnt_rd + 1'b1;
    assign cnt_addr    = (state == ST_COUNT) ? sample_bin : walk_addr;
    assign cnt_wr_en   = walk_en | count_en;
    assign cnt_wr_data = count_en ? cnt_inc : '0;

    random_access_mem #(
        .ADDR_WIDTH (BIN_ADDR_WIDTH),
        .DATA_WIDTH (BIN_COUNTER_WIDTH)
    ) u_bin_mem (
        .clk     (clk),
        .wr_en   (cnt_wr_en),
        .wr_addr (cnt_addr),
        .wr_data (cnt_wr_data),
        .rd_addr (cnt_addr),
        .rd_data (cnt_rd)
    );

    // The label table must stay stable while it is being scanned.
    assign lbl_wr_en = label_wr_en && (state != ST_SCAN);

    random_access_mem #(
        .ADDR_WIDTH (BIN_ADDR_WIDTH),
        .DATA_WIDTH (STATE_WIDTH)
    ) u_label_mem (
        .clk     (clk),
        .wr_en   (lbl_wr_en),
        .wr_addr (label_wr_addr),
        .wr_data (label_wr_data),
        .rd_addr (walk_addr),
        .rd_data (lbl_rd)
    );

    // Accumulate each scanned bin into its labelled state; excluded labels match no state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                acc[s] <= '0;
            end
        end else if (done_en) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                acc[s] <= '0;
            end
        end else if (scan_en) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                if (lbl_rd == STATE_WIDTH'(s)) begin
                    acc[s] <= acc[s] + ACC_WIDTH'(cnt_rd);
                end
            end
        end
    end

    // Argmax with strict comparison so ties resolve to the lowest state index.
    always_comb begin
        best_idx = '0;
        best_val = acc[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (acc[s] > best_val) begin
                best_val = acc[s];
                best_idx = STATE_WIDTH'(s);
            end
        end
    end

    // Result register holds until the next DONE; the strobe trails DONE by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_result_out       <= '0;
            valid_meas_result_out <= 1'b0;
        end else begin
            valid_meas_result_out <= done_en;
            if (done_en) begin
                meas_result_out <= best_idx;
            end
        end
    end

    // Sticky saturation flag, re-armed when a new window opens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_out <= 1'b0;
        end else if (open_window) begin
            overflow_out <= 1'b0;
        end else if (count_en && cnt_at_max) begin
            overflow_out <= 1'b1;
        end
    end

    assign busy_out = fsm_is_busy(state);

endmodule

// File: tb/tb_readout_rx_state_decision_unit_multistate.sv
module tb_readout_rx_state_decision_unit_multistate;

    localparam int DW   = 16;
    localparam int HW   = 2;
    localparam int NS   = 3;
    localparam int CW   = 4;
    localparam int NB   = 16;
    localparam int CMAX = 15;
    // Strobe is expected 17 edges after the edge that sampled finish_count,
    // i.e. 18 cycles after the cycle in which finish_count was high.
    localparam int LAT_EDGES = NB + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            label_wr_en;
    logic [3:0]      label_wr_addr;
    logic [1:0]      label_wr_data;
    logic            start_count;
    logic            finish_count;
    logic            valid_in;
    logic [DW-1:0]   i_in;
    logic [DW-1:0]   q_in;
    logic            busy_out;
    logic            valid_meas_result_out;
    logic [1:0]      meas_result_out;
    logic            overflow_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: histogram with saturating bins, label table, sticky overflow.
    int m_label [NB];
    int m_count [NB];
    bit m_ovf;
    bit m_counting;

    always #5 clk = ~clk;

    readout_rx_state_decision_unit_multistate #(
        .DATA_WIDTH          (DW),
        .BIN_HALF_ADDR_WIDTH (HW),
        .NUM_STATES          (NS),
        .BIN_COUNTER_WIDTH   (CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .label_wr_en           (label_wr_en),
        .label_wr_addr         (label_wr_addr),
        .label_wr_data         (label_wr_data),
        .start_count           (start_count),
        .finish_count          (finish_count),
        .valid_in              (valid_in),
        .i_in                  (i_in),
        .q_in                  (q_in),
        .busy_out              (busy_out),
        .valid_meas_result_out (valid_meas_result_out),
        .meas_result_out       (meas_result_out),
        .overflow_out          (overflow_out)
    );

    // Axis bin from the signed value: shift range to 0..65535, four equal slices.
    function automatic int bin_of(input logic [DW-1:0] i, input logic [DW-1:0] q);
        int ib;
        int qb;
        ib = (int'($signed(i)) + 32768) / 16384;
        qb = (int'($signed(q)) + 32768) / 16384;
        return qb * 4 + ib;
    endfunction

    function automatic int model_result();
        int sums [NS];
        int best;
        for (int s = 0; s < NS; s++) sums[s] = 0;
        for (int b = 0; b < NB; b++) begin
            if (m_label[b] < NS) sums[m_label[b]] += m_count[b];
        end
        best = 0;
        for (int s = 1; s < NS; s++) begin
            if (sums[s] > sums[best]) best = s;
        end
        return best;
    endfunction

    function automatic void model_sample(input logic [DW-1:0] i, input logic [DW-1:0] q);
        int b;
        if (!m_counting) return;
        b = bin_of(i, q);
        if (m_count[b] == CMAX) m_ovf = 1'b1;
        else m_count[b]++;
    endfunction

    function automatic void model_clear_bins();
        for (int b = 0; b < NB; b++) m_count[b] = 0;
    endfunction

    // All stimulus tasks start and end just after a falling edge.
    task automatic release_reset(output int busy_cycles, output bit saw_valid);
        rst = 1'b0;
        busy_cycles = 0;
        saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid_meas_result_out) saw_valid = 1'b1;
            if (!busy_out) break;
            busy_cycles++;
            @(negedge clk);
        end
        model_clear_bins();
        m_ovf = 1'b0;
        m_counting = 1'b0;
    endtask

    task automatic write_labels();
        for (int b = 0; b < NB; b++) begin
            label_wr_en   = 1'b1;
            label_wr_addr = 4'(b);
            label_wr_data = 2'(m_label[b]);
            @(negedge clk);
        end
        label_wr_en = 1'b0;
    endtask

    task automatic start_window();
        start_count = 1'b1;
        @(negedge clk);
        start_count = 1'b0;
        m_ovf = 1'b0;
        m_counting = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] i, input logic [DW-1:0] q);
        valid_in = 1'b1;
        i_in = i;
        q_in = q;
        model_sample(i, q);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Raises finish_count (optionally with a sample in the same cycle), optionally tries
    // a label write mid-scan, then watches for the result strobe within a bounded window.
    task automatic finish_window(input bit with_sample, input logic [DW-1:0] i,
                                 input logic [DW-1:0] q, input bit poke,
                                 output int lat, output int pulses, output logic [1:0] res);
        finish_count = 1'b1;
        if (with_sample) begin
            valid_in = 1'b1;
            i_in = i;
            q_in = q;
            model_sample(i, q);
        end
        @(negedge clk);
        finish_count = 1'b0;
        valid_in = 1'b0;
        m_counting = 1'b0;
        lat = -1;
        pulses = 0;
        res = meas_result_out;
        for (int k = 1; k <= 24; k++) begin
            if (poke && k == 3) begin
                label_wr_en   = 1'b1;
                label_wr_addr = 4'd15;
                label_wr_data = 2'((m_label[15] + 1) % 4);
            end
            @(negedge clk);
            label_wr_en = 1'b0;
            if (valid_meas_result_out) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = meas_result_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        int  bc;
        bit  sv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL rst_busy got=%0b want=1", busy_out); end
        n_vec++; if (valid_meas_result_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b want=0", valid_meas_result_out); end
        n_vec++; if (meas_result_out !== 2'd0) begin n_err++; $display("FAIL rst_result got=%0d want=0", meas_result_out); end
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%0b want=0", overflow_out); end
        // Samples and a stray start during CLEAR must be ignored.
        valid_in = 1'b1;
        start_count = 1'b1;
        release_reset(bc, sv);
        valid_in = 1'b0;
        start_count = 1'b0;
        n_vec++; if (bc !== NB) begin n_err++; $display("FAIL clear_busy_cycles got=%0d want=%0d", bc, NB); end
        n_vec++; if (sv !== 1'b0) begin n_err++; $display("FAIL clear_valid got=%0b want=0", sv); end
        @(negedge clk);
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL idle_after_clear busy got=%0b want=0", busy_out); end
        n_vec++; if ({valid_meas_result_out, meas_result_out, overflow_out} !== 4'b0)
            begin n_err++; $display("FAIL idle_outputs got=%b want=0000", {valid_meas_result_out, meas_result_out, overflow_out}); end
    endtask

    task automatic test_basic();
        int lat;
        int pulses;
        logic [1:0] res;
        for (int b = 0; b < NB; b++) m_label[b] = 3;
        m_label[10] = 1;
        m_label[0]  = 2;
        write_labels();
        start_window();
        repeat (5) send(16'h0000, 16'h0000);
        repeat (3) send(16'h8000, 16'h8000);
        finish_window(1'b0, '0, '0, 1'b0, lat, pulses, res);
        n_vec++; if (lat !== LAT_EDGES) begin n_err++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT_EDGES); end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL basic_pulses got=%0d want=1", pulses); end
        n_vec++; if (res !== 2'(model_result())) begin n_err++; $display("FAIL basic_result got=%0d want=%0d", res, model_result()); end
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL basic_ovf got=%0b want=0", overflow_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got=%0b want=0", busy_out); end
        model_clear_bins();
    endtask

    task automatic test_tie();
        int lat;
        int pulses;
        logic [1:0] res;
        start_window();
        repeat (3) send(16'h0000, 16'h0000);
        repeat (3) send(16'h8000, 16'h8000);
        finish_window(1'b0, '0, '0, 1'b0, lat, pulses, res);
        n_vec++; if (lat !== LAT_EDGES || res !== 2'(model_result()))
            begin n_err++; $display("FAIL tie lat=%0d res=%0d want lat=%0d res=%0d", lat, res, LAT_EDGES, model_result()); end
        model_clear_bins();
    endtask

    task automatic test_saturation();
        int lat;
        int pulses;
        logic [1:0] res;
        start_window();
        repeat (CMAX) send(16'h0000, 16'h0000);
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL sat_ovf_early got=%0b want=0", overflow_out); end
        repeat (5) send(16'h0000, 16'h0000);
        n_vec++; if (overflow_out !== m_ovf) begin n_err++; $display("FAIL sat_ovf got=%0b want=%0b", overflow_out, m_ovf); end
        finish_window(1'b0, '0, '0, 1'b0, lat, pulses, res);
        n_vec++; if (res !== 2'(model_result()) || pulses !== 1)
            begin n_err++; $display("FAIL sat_result got=%0d pulses=%0d want=%0d pulses=1", res, pulses, model_result()); end
        n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL sat_ovf_held got=%0b want=1", overflow_out); end
        model_clear_bins();
    endtask

    task automatic test_scan_clears();
        int lat;
        int pulses;
        logic [1:0] res;
        logic [1:0] held;
        // Samples while idle must not reach the histogram.
        repeat (4) send(16'h0000, 16'h0000);
        n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL idle_ovf_kept got=%0b want=1", overflow_out); end
        start_window();
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL start_ovf_clear got=%0b want=0", overflow_out); end
        repeat (2) send(16'h8000, 16'h8000);
        finish_window(1'b0, '0, '0, 1'b0, lat, pulses, res);
        n_vec++; if (res !== 2'(model_result())) begin n_err++; $display("FAIL second_window got=%0d want=%0d", res, model_result()); end
        held = res;
        model_clear_bins();
        repeat (6) @(negedge clk);
        n_vec++; if (meas_result_out !== held) begin n_err++; $display("FAIL result_hold got=%0d want=%0d", meas_result_out, held); end
        // finish_count alone in IDLE does nothing.
        finish_window(1'b0, '0, '0, 1'b0, lat, pulses, res);
        n_vec++; if (pulses !== 0 || busy_out !== 1'b0)
            begin n_err++; $display("FAIL idle_finish pulses=%0d busy=%0b want 0 0", pulses, busy_out); end
    endtask

    task automatic test_reset_mid_scan();
        int  bc;
        bit  sv;
        int  lat;
        int  pulses;
        logic [1:0] res;
        start_window();
        repeat (4) send(16'h0000, 16'h0000);
        finish_count = 1'b1;
        @(negedge clk);
        finish_count = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL mid_scan_busy got=%0b want=1", busy_out); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (valid_meas_result_out !== 1'b0) begin n_err++; $display("FAIL mid_scan_rst_valid got=%0b want=0", valid_meas_result_out); end
        release_reset(bc, sv);
        n_vec++; if (bc !== NB || sv !== 1'b0)
            begin n_err++; $display("FAIL mid_scan_clear cycles=%0d valid=%0b want %0d 0", bc, sv, NB); end
        repeat (3) @(negedge clk);
        n_vec++; if (valid_meas_result_out !== 1'b0) begin n_err++; $display("FAIL mid_scan_no_result got=%0b want=0", valid_meas_result_out); end
        // Label table survives reset; this window must see only its own samples.
        start_window();
        repeat (2) send(16'h8000, 16'h8000);
        send(16'h0000, 16'h0000);
        finish_window(1'b0, '0, '0, 1'b0, lat, pulses, res);
        n_vec++; if (lat !== LAT_EDGES || res !== 2'(model_result()))
            begin n_err++; $display("FAIL after_rst lat=%0d res=%0d want lat=%0d res=%0d", lat, res, LAT_EDGES, model_result()); end
        model_clear_bins();
    endtask

    task automatic test_random();
        int lat;
        int pulses;
        logic [1:0] res;
        int n;
        logic [DW-1:0] qa;
        logic [DW-1:0] ia;
        logic [DW-1:0] ib;
        logic [DW-1:0] si;
        logic [DW-1:0] sq;
        for (int w = 0; w < 10; w++) begin
            for (int b = 0; b < NB; b++) m_label[b] = int'($urandom_range(0, 3));
            write_labels();
            start_window();
            n  = int'($urandom_range(0, 40));
            qa = 16'($urandom);
            ia = 16'($urandom);
            ib = 16'($urandom);
            for (int s = 0; s < n; s++) begin
                if (w % 2 == 1) begin
                    si = ($urandom_range(0, 2) == 0) ? ib : ia;
                    sq = qa;
                end else begin
                    si = 16'($urandom);
                    sq = 16'($urandom);
                end
                send(si, sq);
            end
            si = 16'($urandom);
            sq = 16'($urandom);
            finish_window(1'b1, si, sq, 1'b1, lat, pulses, res);
            n_vec++; if (lat !== LAT_EDGES || pulses !== 1)
                begin n_err++; $display("FAIL rand%0d_timing lat=%0d pulses=%0d want %0d 1", w, lat, pulses, LAT_EDGES); end
            n_vec++; if (res !== 2'(model_result()))
                begin n_err++; $display("FAIL rand%0d_result got=%0d want=%0d", w, res, model_result()); end
            n_vec++; if (overflow_out !== m_ovf)
                begin n_err++; $display("FAIL rand%0d_ovf got=%0b want=%0b", w, overflow_out, m_ovf); end
            model_clear_bins();
        end
    endtask

    initial begin
        rst           = 1'b1;
        label_wr_en   = 1'b0;
        label_wr_addr = '0;
        label_wr_data = '0;
        start_count   = 1'b0;
        finish_count  = 1'b0;
        valid_in      = 1'b0;
        i_in          = '0;
        q_in          = '0;
        m_ovf         = 1'b0;
        m_counting    = 1'b0;
        for (int b = 0; b < NB; b++) begin
            m_label[b] = 3;
            m_count[b] = 0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_scan_clears();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/readout_rx_state_decision_unit_multistate.md
READOUT_RX_STATE_DECISION_UNIT_MULTISTATE -- requirements
Module: readout_rx_state_decision_unit_multistate

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, I/Q sample width (two's complement); BIN_HALF_ADDR_WIDTH, default 4, bins per axis = 2^BIN_HALF_ADDR_WIDTH; NUM_STATES, default 3, range 2..4; BIN_COUNTER_WIDTH, default 16, per-bin counter width.
REQ-002 SHALL derive localparams: BIN_ADDR_WIDTH = 2*BIN_HALF_ADDR_WIDTH; NUM_BINS = 2^BIN_ADDR_WIDTH; STATE_WIDTH = 2; ACC_WIDTH = BIN_COUNTER_WIDTH+BIN_ADDR_WIDTH.
REQ-003 SHALL have ports, in this order:
  clk  in  1  clock, single domain.
  rst  in  1  reset; asynchronous, active-high.
  label_wr_en  in  1  write strobe for the bin state-label table.
  label_wr_addr  in  BIN_ADDR_WIDTH  bin index {q_bin,i_bin}.
  label_wr_data  in  STATE_WIDTH  state label; values >= NUM_STATES exclude the bin.
  start_count  in  1  open a measurement window.
  finish_count  in  1  close window, start classification.
  valid_in  in  1  I/Q sample strobe.
  i_in, q_in  in  DATA_WIDTH each  signed samples.
  busy_out  out  1  high in CLEAR, SCAN and DONE.
  valid_meas_result_out  out  1  one-cycle result strobe.
  meas_result_out  out  STATE_WIDTH  classified state.
  overflow_out  out  1  sticky: some bin saturated in this window.

Function
REQ-004 SHALL implement FSM states CLEAR, IDLE, COUNT, SCAN, DONE.
REQ-005 Bin address SHALL be {q_u[top BIN_HALF_ADDR_WIDTH], i_u[top BIN_HALF_ADDR_WIDTH]}, where x_u inverts the sign bit of x (offset binary).
REQ-006 CLEAR: write 0 to bin addresses 0..NUM_BINS-1, one per cycle, then go to IDLE; start_count and finish_count are ignored.
REQ-007 IDLE: start_count -> COUNT next cycle and overflow_out cleared; finish_count alone ignored; both high -> start_count wins.
REQ-008 COUNT: each valid_in increments its bin in the same cycle (combinational read, synchronous write); at counter max the value holds and overflow_out sets.
REQ-009 COUNT: start_count ignored; finish_count -> SCAN; a valid_in in the finish_count cycle is counted.
REQ-010 valid_in outside COUNT SHALL be dropped.
REQ-011 SCAN: visit addr k = 0..NUM_BINS-1 over NUM_BINS cycles; if label(k) < NUM_STATES, add count(k) to acc[label(k)]; write 0 to bin k in the same cycle; then DONE.
REQ-012 DONE: register meas_result_out = argmax(acc), ties to lowest index; clear all acc; go to IDLE. valid_meas_result_out SHALL pulse high one cycle, the cycle after DONE.
REQ-013 Latency: finish_count sampled at cycle t -> valid_meas_result_out high at cycle t+NUM_BINS+2.
REQ-014 Label writes SHALL be accepted in every state except SCAN, where they are dropped. Label table contents are not reset.
REQ-015 Accumulators at ACC_WIDTH cannot overflow and SHALL NOT saturate.
REQ-016 meas_result_out SHALL hold its value until the next DONE.

Reset
REQ-017 On rst: state = CLEAR, clear address 0, acc all 0; valid_meas_result_out, meas_result_out and overflow_out = 0; busy_out = 1.
REQ-018 rst in any state, including mid-COUNT or mid-SCAN, SHALL abort the window and rerun CLEAR; no result is produced.

Structure
REQ-019 FSM state encoding and the STATE_WIDTH/label constants SHALL live in the shared readout_rx package.
REQ-020 The bin count memory and the label table SHALL each instantiate random_access_mem (combinational read, synchronous write, no reset); there SHALL be no per-bin valid bitmap, since clearing is done by CLEAR/SCAN write-back.

Verification (BIN_HALF_ADDR_WIDTH=2, NUM_STATES=3, BIN_COUNTER_WIDTH=4)
REQ-021 Release rst -> busy_out high exactly 16 cycles, then low; all outputs 0.
REQ-022 Labels bin10=1, bin0=2, others=3. Samples: 5x (i,q)=(0,0) -> bin10; 3x (0x8000,0x8000) -> bin0. Finish -> valid 18 cycles after finish_count, meas_result_out=1.
REQ-023 Tie: 3 samples in bin10, 3 in bin0 -> meas_result_out=1.
REQ-024 20 samples in bin10 -> count saturates at 15, overflow_out=1 until next start_count, result=1.
REQ-025 Second window with only 2 samples in bin0 -> result=2 (proves SCAN cleared bins); valid_in in IDLE changes nothing.
REQ-026 rst asserted mid-SCAN -> no valid pulse, 16-cycle CLEAR reruns, next window classifies correctly.
